// File: rtl/vga_sync.sv
// vga_sync -- 640x480 @ 60 Hz VGA timing generator.
//
// Divides the system clock by CLK_DIV to form a pixel strobe and walks an
// (x, y) raster through display, front porch, sync and back porch. Every
// output is a register loaded from the next-state raster position, so the
// coordinate, the blanking flag and both syncs always change together on
// the same clock edge.
//
// Ports:
//   clk        in   system clock (100 MHz nominal)
//   reset      in   asynchronous, active-low reset
//   p_tick     out  one-clk pixel strobe, once every CLK_DIV clks
//   x          out  horizontal position, 0..H_TOTAL-1
//   y          out  vertical position, 0..V_TOTAL-1
//   video_on   out  high while (x, y) lies in the visible area
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   frame_tick out  one-clk pulse on the clk where (x, y) wraps to (0, 0)
//   frame_cnt  out  16-bit frame counter, present only when the macro
//                   VGA_SYNC_FRAME_CNT_EN is defined
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN (adds frame_cnt).

module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // The coordinates are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024) begin : g_h_total_too_big
            $error("vga_sync: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_too_big
            $error("vga_sync: V_TOTAL exceeds 1024");
        end
        if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_clk_div_range
            $error("vga_sync: CLK_DIV must be within 2..16");
        end
    endgenerate

    localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    // 11-bit visible limits so a display width of 1024 cannot alias to 0.
    localparam logic [10:0] X_VISIBLE = 11'(H_DISPLAY);
    localparam logic [10:0] Y_VISIBLE = 11'(V_DISPLAY);

    logic [3:0] div;
    logic [3:0] div_next;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       frame_wrap;
    logic       p_tick_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       video_on_next;

    // Next-state raster position. p_tick is high for exactly the clk in which
    // div == CLK_DIV-1, so the edge ending that clk is the one that advances.
    always_comb begin
        div_next   = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        x_next     = x;
        y_next     = y;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (x == X_LAST) begin
                x_next = 10'd0;
                if (y == Y_LAST) begin
                    y_next     = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = y + 10'd1;
                end
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Decode from the next-state values so the registered syncs and blanking
    // line up with the registered coordinate.
    always_comb begin
        p_tick_next   = (div_next == DIV_LAST);
        hsync_next    = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
        vsync_next    = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
        video_on_next = ({1'b0, x_next} < X_VISIBLE) && ({1'b0, y_next} < Y_VISIBLE);
    end

    // Reset values describe pixel (0,0) with div = 0: visible, syncs idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div        <= 4'd0;
            p_tick     <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            video_on   <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            div        <= div_next;
            p_tick     <= p_tick_next;
            x          <= x_next;
            y          <= y_next;
            video_on   <= video_on_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            frame_tick <= frame_wrap;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Counts raster wraps; it steps on the same edge that raises frame_tick
    // and rolls over naturally from 65535 to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 16'd0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync -- bench for vga_sync.
//
// Two instances share one clock: u_def runs the full 640x480 raster and is
// used for line-level timing; u_sm runs a tiny raster (CLK_DIV=3, 13x9) so
// whole frames fit in a short run. Both are compared every clk against a
// reference model that derives the expected outputs from the number of clk
// edges seen since reset release, using plain division and modulo.

module tb_vga_sync;

  localparam int DD  = 4;
  localparam int SD  = 3;
  localparam int SHD = 6;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 2;
  localparam int SVD = 4;
  localparam int SVF = 1;
  localparam int SVS = 2;
  localparam int SVB = 2;
  localparam int S_HT = SHD + SHF + SHS + SHB;
  localparam int S_VT = SVD + SVF + SVS + SVB;
  localparam int S_FRAME = SD * S_HT * S_VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       p_tick;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
  } out_t;

  typedef struct {
    int   c;
    out_t e;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;
  logic rst_s;

  logic       pt_d, vo_d, hs_d, vs_d, ft_d;
  logic [9:0] x_d, y_d;
  logic       pt_s, vo_s, hs_s, vs_s, ft_s;
  logic [9:0] x_s, y_s;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  vga_sync u_def (
    .clk        (clk),
    .reset      (rst_d),
    .p_tick     (pt_d),
    .x          (x_d),
    .y          (y_d),
    .video_on   (vo_d),
    .hsync      (hs_d),
    .vsync      (vs_d),
    .frame_tick (ft_d)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt  (fc_d)
`endif
  );

  vga_sync #(
    .CLK_DIV   (SD),
    .H_DISPLAY (SHD),
    .H_FRONT   (SHF),
    .H_SYNC    (SHS),
    .H_BACK    (SHB),
    .V_DISPLAY (SVD),
    .V_FRONT   (SVF),
    .V_SYNC    (SVS),
    .V_BACK    (SVB)
  ) u_sm (
    .clk        (clk),
    .reset      (rst_s),
    .p_tick     (pt_s),
    .x          (x_s),
    .y          (y_s),
    .video_on   (vo_s),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .frame_tick (ft_s)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt  (fc_s)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int c_d = 0;
  int c_s = 0;

  bit collect = 1'b1;
  int hs_low = 0;
  int hs_first_x = -1;
  int vs_low = 0;
  int n_ft = 0;
  int ft_c[2];

  // ---------------- reference model ----------------
  function automatic out_t model(int c, int d, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    int   ht, vt, n, xi, yi;
    out_t m;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    n  = c / d;
    xi = n % ht;
    yi = (n / ht) % vt;
    m.x          = 10'(xi);
    m.y          = 10'(yi);
    m.p_tick     = (c % d == d - 1);
    m.video_on   = (xi < hd) && (yi < vd);
    m.hsync      = !((xi >= hd + hf) && (xi < hd + hf + hs));
    m.vsync      = !((yi >= vd + vf) && (yi < vd + vf + vs));
    m.frame_tick = (c % d == 0) && (n > 0) && (n % (ht * vt) == 0);
    return m;
  endfunction

  function automatic out_t model_d(int c);
    return model(c, DD, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic out_t model_s(int c);
    return model(c, SD, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
  endfunction

  function automatic out_t mk(int xi, int yi, int p, int v, int h, int vs, int f);
    out_t m;
    m.x          = 10'(xi);
    m.y          = 10'(yi);
    m.p_tick     = 1'(p);
    m.video_on   = 1'(v);
    m.hsync      = 1'(h);
    m.vsync      = 1'(vs);
    m.frame_tick = 1'(f);
    return m;
  endfunction

  function automatic out_t act_d();
    return {x_d, y_d, pt_d, vo_d, hs_d, vs_d, ft_d};
  endfunction

  function automatic out_t act_s();
    return {x_s, y_s, pt_s, vo_s, hs_s, vs_s, ft_s};
  endfunction

  // ---------------- compare helpers ----------------
  task automatic cmp(string name, int c, out_t a, out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s c=%0d actual x=%0d y=%0d p=%b v=%b h=%b vs=%b f=%b required x=%0d y=%0d p=%b v=%b h=%b vs=%b f=%b",
               name, c, a.x, a.y, a.p_tick, a.video_on, a.hsync, a.vsync, a.frame_tick,
               e.x, e.y, e.p_tick, e.video_on, e.hsync, e.vsync, e.frame_tick);
    end
  endtask

  task automatic cmp_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  // ---------------- driver: one clk, then check at negedge ----------------
  task automatic step();
    @(posedge clk);
    if (rst_d) c_d++;
    if (rst_s) c_s++;
    @(negedge clk);
    cmp("def_model", c_d, act_d(), model_d(c_d));
    cmp("small_model", c_s, act_s(), model_s(c_s));
`ifdef VGA_SYNC_FRAME_CNT_EN
    cmp_int("small_frame_cnt", int'(fc_s), ((c_s / SD) / (S_HT * S_VT)) % 65536);
    cmp_int("def_frame_cnt", int'(fc_d), ((c_d / DD) / 420000) % 65536);
`endif
    if (collect) begin
      if (c_d <= 3199 && !hs_d) begin
        hs_low++;
        if (hs_low == 1) hs_first_x = int'(x_d);
      end
      if (c_s < S_FRAME && !vs_s) vs_low++;
      if (ft_s && n_ft < 2) begin
        ft_c[n_ft] = c_s;
        n_ft++;
      end
    end
  endtask

  // Assert reset between edges and check the outputs before any edge arrives.
  task automatic async_reset(int sel, int dly);
    #(dly);
    if (sel != 1) rst_d = 1'b0;
    if (sel != 0) rst_s = 1'b0;
    #1;
    if (sel != 1) begin
      cmp("def_async_reset", 0, act_d(), mk(0, 0, 0, 1, 1, 1, 0));
      c_d = 0;
    end
    if (sel != 0) begin
      cmp("small_async_reset", 0, act_s(), mk(0, 0, 0, 1, 1, 1, 0));
      c_s = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[12];

  initial begin
    int guard;

    tbl[0]  = '{0,    mk(0,   0, 0, 1, 1, 1, 0)};
    tbl[1]  = '{3,    mk(0,   0, 1, 1, 1, 1, 0)};
    tbl[2]  = '{4,    mk(1,   0, 0, 1, 1, 1, 0)};
    tbl[3]  = '{2559, mk(639, 0, 1, 1, 1, 1, 0)};
    tbl[4]  = '{2560, mk(640, 0, 0, 0, 1, 1, 0)};
    tbl[5]  = '{2623, mk(655, 0, 1, 0, 1, 1, 0)};
    tbl[6]  = '{2624, mk(656, 0, 0, 0, 0, 1, 0)};
    tbl[7]  = '{3007, mk(751, 0, 1, 0, 0, 1, 0)};
    tbl[8]  = '{3008, mk(752, 0, 0, 0, 1, 1, 0)};
    tbl[9]  = '{3199, mk(799, 0, 1, 0, 1, 1, 0)};
    tbl[10] = '{3200, mk(0,   1, 0, 1, 1, 1, 0)};
    tbl[11] = '{3203, mk(0,   1, 1, 1, 1, 1, 0)};

    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (5) step();
    cmp("reset_values_def", 0, act_d(), mk(0, 0, 0, 1, 1, 1, 0));
    cmp("reset_values_small", 0, act_s(), mk(0, 0, 0, 1, 1, 1, 0));
    rst_d = 1'b1;
    rst_s = 1'b1;

    // Table vectors on the full-size raster.
    for (int i = 0; i < 12; i++) begin
      while (c_d < tbl[i].c) step();
      cmp($sformatf("vec%0d", i), c_d, act_d(), tbl[i].e);
    end
    while (c_d < 3210) step();
    collect = 1'b0;

    // Line and frame level timing.
    cmp_int("hsync_low_clks", hs_low, 96 * DD);
    cmp_int("hsync_first_x", hs_first_x, 656);
    cmp_int("vsync_low_clks", vs_low, SVS * S_HT * SD);
    cmp_int("frame_tick_count", n_ft, 2);
    cmp_int("first_frame_tick_clk", ft_c[0], S_FRAME);
    cmp_int("frame_tick_period", ft_c[1] - ft_c[0], S_FRAME);

    // Mid-frame reset on the small raster at y=2, x=7, one clk into the pixel.
    guard = 0;
    while (!(((c_s / SD) % (S_HT * S_VT)) == 2 * S_HT + 7 && (c_s % SD) == 1) && guard < 2 * S_FRAME) begin
      step();
      guard++;
    end
    cmp_int("small_midframe_reach", guard < 2 * S_FRAME ? 1 : 0, 1);
    async_reset(1, 2);
    repeat (2) step();
    rst_s = 1'b1;
    repeat (12) step();

    // Mid-line reset on the full raster at x=400, partway through a pixel.
    guard = 0;
    while (!(((c_d / DD) % 800) == 400 && (c_d % DD) == 2) && guard < 4000) begin
      step();
      guard++;
    end
    cmp_int("def_midline_reach", guard < 4000 ? 1 : 0, 1);
    async_reset(0, 3);
    repeat (3) step();
    rst_d = 1'b1;
    repeat (12) step();

    // Randomised reset pulses at random points of the raster.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(10, 600)) step();
      async_reset(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(1, 3)) step();
      rst_d = 1'b1;
      rst_s = 1'b1;
    end
    repeat (2 * S_FRAME) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
